sev_seg_reader: RTL and testbench

SEV_SEG_READER -- requirements
Module: sev_seg_reader

---
 rtl/sev_seg_pkg.sv | 20 ++
 rtl/sev_seg_encoder.sv | 33 +++
 rtl/sev_seg_reader.sv | 106 ++++++++++
 tb/tb_sev_seg_reader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: shared segment patterns (g..a, active-low) and FSM states
// for the multiplexed 7-segment reader.
package sev_seg_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/sev_seg_encoder.sv
// sev_seg_encoder: maps an active-low g..a pattern to {hex, legal, blank}.
// B and D are absent because their drive patterns alias 8 and 0.
module sev_seg_encoder
  import sev_seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] hex,
  output logic       legal,
  output logic       blank
);
  always_comb begin
    hex = 4'h0;
    legal = 1'b1;
    blank = pat == SEG_BLANK;
    case (pat)
      SEG_0: hex = 4'h0;
      SEG_1: hex = 4'h1;
      SEG_2: hex = 4'h2;
      SEG_3: hex = 4'h3;
      SEG_4: hex = 4'h4;
      SEG_5: hex = 4'h5;
      SEG_6: hex = 4'h6;
      SEG_7: hex = 4'h7;
      SEG_8: hex = 4'h8;
      SEG_9: hex = 4'h9;
      SEG_A: hex = 4'hA;
      SEG_C: hex = 4'hC;
      SEG_E: hex = 4'hE;
      SEG_F: hex = 4'hF;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/sev_seg_reader.sv
// sev_seg_reader: snoops a multiplexed active-low 7-segment bus and recovers
// per-digit hex value, decimal point and freshness.
module sev_seg_reader
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int RW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              sev_seg,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_dp,
  output logic [NUM_DIGITS-1:0]   digit_vld,
  output logic                    upd,
  output logic [IW-1:0]           upd_idx,
  output logic                    err
);
  localparam int SW = 8 + NUM_DIGITS;
  logic [SW-1:0] s1, s2, prev;
  state_t state;
  logic [7:0] count;
  logic [NUM_DIGITS-1:0] act, pact;
  logic one_hot, multi, multi_q, same, cap, legal, blank;
  logic [IW-1:0] idx;
  logic [3:0] hex;
  logic [RW-1:0] rcnt [NUM_DIGITS];
  assign act = ~s2[NUM_DIGITS-1:0];
  assign pact = ~prev[NUM_DIGITS-1:0];
  assign multi = (act & (act - NUM_DIGITS'(1))) != '0;
  assign one_hot = act != '0 && !multi;
  assign same = s2 == prev;
  // Capture fires on the sample that brings the run length to STABLE_CYCLES,
  // which keeps pin-to-upd latency at 2 + STABLE_CYCLES.
  assign cap = state == SETTLE && same && count == 8'(STABLE_CYCLES - 1);
  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) if (pact[k]) idx = IW'(k);
  end
  sev_seg_encoder u_enc (
    .pat(prev[NUM_DIGITS+6:NUM_DIGITS]),
    .hex(hex),
    .legal(legal),
    .blank(blank)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      prev <= '1;
      state <= IDLE;
      count <= '0;
      multi_q <= 1'b0;
      upd <= 1'b0;
      upd_idx <= '0;
      err <= 1'b0;
    end else begin
      s1 <= {sev_seg, an_n};
      s2 <= s1;
      prev <= s2;
      multi_q <= multi;
      upd <= cap;
      err <= (cap && !legal && !blank) || (multi && !multi_q);
      if (cap) upd_idx <= idx;
      case (state)
        IDLE: if (one_hot) begin
          state <= SETTLE;
          count <= 8'd1;
        end
        default: if (same) begin
          if (state == SETTLE) count <= count == 8'hff ? count : count + 8'd1;
          if (cap) state <= HOLD;
        end else if (one_hot) begin
          state <= SETTLE;
          count <= 8'd1;
        end else state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val <= '0;
      digit_dp <= '0;
      digit_vld <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) rcnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap && idx == IW'(k)) begin
          rcnt[k] <= '0;
          digit_vld[k] <= legal;
          if (legal) begin
            digit_val[4*k +: 4] <= hex;
            digit_dp[k] <= ~prev[SW-1];
          end
        end else begin
          rcnt[k] <= rcnt[k] == RW'(TIMEOUT_CYCLES) ? rcnt[k] : rcnt[k] + RW'(1);
          if (rcnt[k] == RW'(TIMEOUT_CYCLES)) digit_vld[k] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sev_seg_reader.sv
// tb_sev_seg_reader: table of digit slots plus scan, glitch, multi-enable,
// timeout and reset sequences, checked through a capture scoreboard.
module tb_sev_seg_reader;
  localparam int ND = 4, S = 4, TO = 300;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] sev_seg = '1;
  logic [ND-1:0] an_n = '1;
  logic [4*ND-1:0] digit_val;
  logic [ND-1:0] digit_dp, digit_vld;
  logic upd, err;
  logic [1:0] upd_idx;
  typedef struct packed {logic [1:0] idx; logic [3:0] val; logic dp; logic vld; logic err;} exp_t;
  typedef struct packed {logic [3:0] an; logic [7:0] seg; exp_t e;} vec_t;
  exp_t q[$];
  exp_t me;
  int total = 0, passed = 0, nupd = 0, merr = 0;

  sev_seg_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sev_seg(sev_seg), .an_n(an_n),
    .digit_val(digit_val), .digit_dp(digit_dp), .digit_vld(digit_vld),
    .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(logic [3:0] an, logic [7:0] seg, exp_t e, int len);
    an_n = an;
    sev_seg = seg;
    q.push_back(e);
    tick(len);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (err && !upd) merr++;
    if (upd) begin
      nupd++;
      chk("upd_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("upd_idx", upd_idx, me.idx);
        chk("digit_val", digit_val[4*me.idx +: 4], me.val);
        chk("digit_dp", digit_dp[me.idx], me.dp);
        chk("digit_vld", digit_vld[me.idx], me.vld);
        chk("cap_err", err, me.err);
      end
    end
  end

  initial begin
    vec_t tbl[16];
    int b, b2, lat;
    tbl[0]  = '{4'b1110, 8'b1_0110000, '{2'd0, 4'h3, 1'b0, 1'b1, 1'b0}};
    tbl[1]  = '{4'b1101, 8'b0_1111001, '{2'd1, 4'h1, 1'b1, 1'b1, 1'b0}};
    tbl[2]  = '{4'b1011, 8'b1_0001000, '{2'd2, 4'hA, 1'b0, 1'b1, 1'b0}};
    tbl[3]  = '{4'b0111, 8'b1_1000110, '{2'd3, 4'hC, 1'b0, 1'b1, 1'b0}};
    tbl[4]  = '{4'b1110, 8'b0_0000000, '{2'd0, 4'h8, 1'b1, 1'b1, 1'b0}};
    tbl[5]  = '{4'b1101, 8'b1_0111111, '{2'd1, 4'h1, 1'b1, 1'b0, 1'b1}};
    tbl[6]  = '{4'b1011, 8'b1_1111111, '{2'd2, 4'hA, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{4'b0111, 8'b1_0000110, '{2'd3, 4'hE, 1'b0, 1'b1, 1'b0}};
    tbl[8]  = '{4'b1110, 8'b1_0010010, '{2'd0, 4'h5, 1'b0, 1'b1, 1'b0}};
    tbl[9]  = '{4'b1101, 8'b1_1000000, '{2'd1, 4'h0, 1'b0, 1'b1, 1'b0}};
    tbl[10] = '{4'b1011, 8'b1_0001110, '{2'd2, 4'hF, 1'b0, 1'b1, 1'b0}};
    tbl[11] = '{4'b0111, 8'b0_0100100, '{2'd3, 4'h2, 1'b1, 1'b1, 1'b0}};
    tbl[12] = '{4'b1110, 8'b1_0000010, '{2'd0, 4'h6, 1'b0, 1'b1, 1'b0}};
    tbl[13] = '{4'b1101, 8'b0_1111000, '{2'd1, 4'h7, 1'b1, 1'b1, 1'b0}};
    tbl[14] = '{4'b1011, 8'b1_0011001, '{2'd2, 4'h4, 1'b0, 1'b1, 1'b0}};
    tbl[15] = '{4'b0111, 8'b1_0010000, '{2'd3, 4'h9, 1'b0, 1'b1, 1'b0}};
    tick(3);
    chk("rst_val", digit_val, 0);
    chk("rst_dp", digit_dp, 0);
    chk("rst_vld", digit_vld, 0);
    chk("rst_upd", upd, 0);
    chk("rst_idx", upd_idx, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick(4);
    for (int i = 0; i < 16; i++) begin
      b = nupd;
      slot(tbl[i].an, tbl[i].seg, tbl[i].e, 10);
      chk("slot_drain", q.size(), 0);
      chk("slot_one_upd", nupd - b, 1);
    end
    // glitch inside a digit-0 slot must not be captured
    b = nupd;
    an_n = 4'b1110;
    sev_seg = 8'b1_0110000;
    q.push_back('{2'd0, 4'h3, 1'b0, 1'b1, 1'b0});
    tick(3);
    sev_seg = 8'b1_0000000;
    tick(2);
    sev_seg = 8'b1_0110000;
    tick(10);
    chk("glitch_upds", nupd - b, 1);
    chk("glitch_val", digit_val[3:0], 4'h3);
    // two scans of "8.0E1"
    for (int s = 0; s < 2; s++) begin
      b = nupd;
      slot(4'b0111, 8'b0_0000000, '{2'd3, 4'h8, 1'b1, 1'b1, 1'b0}, 8);
      slot(4'b1011, 8'b1_1000000, '{2'd2, 4'h0, 1'b0, 1'b1, 1'b0}, 8);
      slot(4'b1101, 8'b1_0000110, '{2'd1, 4'hE, 1'b0, 1'b1, 1'b0}, 8);
      slot(4'b1110, 8'b1_1111001, '{2'd0, 4'h1, 1'b0, 1'b1, 1'b0}, 8);
      chk("scan_upds", nupd - b, 4);
    end
    chk("scan_val", digit_val, 16'h80E1);
    chk("scan_dp", digit_dp, 4'b1000);
    chk("scan_vld", digit_vld, 4'b1111);
    // two enables low at once
    b = merr;
    b2 = nupd;
    an_n = 4'b1100;
    sev_seg = 8'b1_0110000;
    tick(10);
    chk("multi_err", merr - b, 1);
    chk("multi_no_upd", nupd - b2, 0);
    // digit 2 captured once, then left out of the scan until it times out
    slot(4'b1011, 8'b1_0010010, '{2'd2, 4'h5, 1'b0, 1'b1, 1'b0}, 8);
    for (int s = 0; s < 14; s++) begin
      slot(4'b1110, 8'b1_1111001, '{2'd0, 4'h1, 1'b0, 1'b1, 1'b0}, 8);
      slot(4'b1101, 8'b1_0000110, '{2'd1, 4'hE, 1'b0, 1'b1, 1'b0}, 8);
      slot(4'b0111, 8'b0_0000000, '{2'd3, 4'h8, 1'b1, 1'b1, 1'b0}, 8);
      if (s == 9) chk("to_before", digit_vld, 4'b1111);
    end
    chk("to_after", digit_vld, 4'b1011);
    chk("to_drain", q.size(), 0);
    // reset in the middle of a settle
    an_n = 4'b1101;
    sev_seg = 8'b1_0100100;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_val", digit_val, 0);
    chk("mid_rst_dp", digit_dp, 0);
    chk("mid_rst_vld", digit_vld, 0);
    chk("mid_rst_upd", upd, 0);
    chk("mid_rst_err", err, 0);
    tick(2);
    rst_n = 1'b1;
    q.push_back('{2'd1, 4'h2, 1'b0, 1'b1, 1'b0});
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (upd) lat = k;
    end
    chk("rst_latency", lat, 2 + S);
    tick(5);
    chk("final_drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
